// File: rtl/stbus_frame_master.sv
// ST-BUS style frame master: generates C4 and the active-low F0 frame pulse,
// serializes one TX word per frame onto DX and deserializes one RX word from DR.
module stbus_frame_master #(
    parameter int unsigned             FRAME_BITS = 32,
    parameter int unsigned             DIV        = 1,
    parameter logic [FRAME_BITS-1:0]   IDLE_WORD  = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy,
    output logic                  c4_o,
    output logic                  f0_n_o,
    output logic                  dx_o,
    input  logic                  dr_i
);

    localparam int unsigned PHASES = 4 * FRAME_BITS;
    localparam int unsigned PW     = $clog2(PHASES);
    localparam int unsigned DW     = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] P_LAST   = PW'(PHASES - 1);
    localparam logic [PW-1:0] P_F0     = PW'(PHASES - 2);
    localparam logic [PW-1:0] P_PRE    = PW'(PHASES - 3);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {StIdle, StSync, StRun} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           p_q;
    logic [DW-1:0]           div_q;
    logic                    cont_q;
    logic [FRAME_BITS-1:0]   hold_q;
    logic                    hold_valid_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [FRAME_BITS-1:0]   rx_shift_q;
    logic [FRAME_BITS-1:0]   rx_data_q;
    logic                    rx_valid_q;
    logic                    underrun_q;

    logic tick;       // last clk of the current half-period
    logic first;      // first clk of the current half-period
    logic frame_end;  // last clk of p=4F-1
    logic load;       // edge that starts a new frame at p=0

    // Next-state decode and frame-start load strobe
    always_comb begin
        tick      = (div_q == DIV_LAST);
        first     = (div_q == '0);
        frame_end = tick && (p_q == P_LAST);
        state_d   = state_q;
        load      = 1'b0;
        unique case (state_q)
            StIdle: if (en) state_d = StSync;
            StSync: begin
                if (frame_end) begin
                    state_d = StRun;
                    load    = 1'b1;
                end
            end
            StRun: begin
                if (frame_end) begin
                    if (cont_q) load    = 1'b1;
                    else        state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, timebase, TX and RX datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            p_q          <= P_F0;
            div_q        <= '0;
            cont_q       <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '1;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;

            // SYNC always starts two half-periods before p=0
            if (state_q == StIdle) begin
                div_q <= '0;
                p_q   <= P_F0;
            end else begin
                div_q <= tick ? '0 : div_q + DW'(1);
                if (tick) p_q <= (p_q == P_LAST) ? '0 : p_q + PW'(1);
            end

            // en is taken as p enters 4F-2 so F0 covers the whole 4F-2..4F-1 window
            if (state_q == StRun && tick && p_q == P_PRE) cont_q <= en;

            if (load) begin
                shift_q    <= hold_valid_q ? hold_q : IDLE_WORD;
                underrun_q <= !hold_valid_q;
            end else if (state_q == StRun && tick && p_q[1:0] == 2'b11) begin
                shift_q <= {shift_q[FRAME_BITS-2:0], 1'b1};
            end

            // A word offered on the load edge with holding empty lands in holding
            if (tx_valid && !hold_valid_q) begin
                hold_q       <= tx_data;
                hold_valid_q <= 1'b1;
            end else if (load) begin
                hold_valid_q <= 1'b0;
            end

            // Mid-bit sample on the first clk of p=4b+2
            if (state_q == StRun && first && p_q[1:0] == 2'b10) begin
                rx_shift_q <= {rx_shift_q[FRAME_BITS-2:0], dr_i};
            end

            if (state_q == StRun && frame_end) begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
            end
        end
    end

    // Line and host outputs decoded from registered state
    always_comb begin
        busy        = (state_q != StIdle);
        c4_o        = busy && p_q[0];
        f0_n_o      = !((state_q == StSync) ||
                        (state_q == StRun && cont_q && p_q >= P_F0));
        dx_o        = (state_q == StRun) ? shift_q[FRAME_BITS-1] : 1'b1;
        tx_ready    = !hold_valid_q;
        rx_data     = rx_data_q;
        rx_valid    = rx_valid_q;
        tx_underrun = underrun_q;
    end

endmodule

// File: tb/tb_stbus_frame_master.sv
// Directed bench for stbus_frame_master: a 32-bit DIV=1 instance and an 8-bit DIV=3 instance.
module tb_stbus_frame_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: FRAME_BITS=32, DIV=1
    logic        en_a = 1'b0;
    logic [31:0] tx_data_a = '0;
    logic        tx_valid_a = 1'b0;
    logic        tx_ready_a, rx_valid_a, tx_underrun_a, busy_a, c4_a, f0n_a, dx_a;
    logic [31:0] rx_data_a;
    logic        dr_drv_a = 1'b0;
    logic        loop_a = 1'b0;
    logic        dr_a;
    assign dr_a = loop_a ? dx_a : dr_drv_a;

    // Instance B: FRAME_BITS=8, DIV=3
    logic       en_b = 1'b0;
    logic       tx_ready_b, rx_valid_b, tx_underrun_b, busy_b, c4_b, f0n_b, dx_b;
    logic [7:0] rx_data_b;
    logic       dr_b = 1'b0;

    stbus_frame_master #(.FRAME_BITS(32), .DIV(1)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .tx_underrun(tx_underrun_a), .busy(busy_a), .c4_o(c4_a), .f0_n_o(f0n_a),
        .dx_o(dx_a), .dr_i(dr_a)
    );

    stbus_frame_master #(.FRAME_BITS(8), .DIV(3)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .tx_data(8'h00), .tx_valid(1'b0),
        .tx_ready(tx_ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .tx_underrun(tx_underrun_b), .busy(busy_b), .c4_o(c4_b), .f0_n_o(f0n_b),
        .dx_o(dx_b), .dr_i(dr_b)
    );

    int total = 0;
    int bad   = 0;
    int errs;
    int lows;
    logic [31:0] word;
    logic [7:0]  pat;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_a(input string pfx);
        chk({pfx, "_c4"},       32'(c4_a),          32'd0);
        chk({pfx, "_f0n"},      32'(f0n_a),         32'd1);
        chk({pfx, "_dx"},       32'(dx_a),          32'd1);
        chk({pfx, "_txready"},  32'(tx_ready_a),    32'd1);
        chk({pfx, "_rxvalid"},  32'(rx_valid_a),    32'd0);
        chk({pfx, "_underrun"}, 32'(tx_underrun_a), 32'd0);
        chk({pfx, "_busy"},     32'(busy_a),        32'd0);
        chk({pfx, "_rxdata"},   rx_data_a,          32'd0);
    endtask

    initial begin
        step();
        step();
        chk_reset_a("rst");
        rst = 1'b0;
        step();

        // 1: no TX word, dr=0 -> IDLE_WORD frame, rx word 0
        en_a = 1'b1;
        step();
        chk("t1_sync0_f0n", 32'(f0n_a), 32'd0);
        chk("t1_sync0_c4",  32'(c4_a),  32'd0);
        step();
        chk("t1_sync1_f0n", 32'(f0n_a), 32'd1 - 32'd1);
        chk("t1_sync1_c4",  32'(c4_a),  32'd1);
        step();
        chk("t1_clk0_underrun", 32'(tx_underrun_a), 32'd1);
        errs = 0;
        for (int k = 0; k < 128; k++) begin
            if (dx_a !== 1'b1) errs++;
            if (c4_a !== 1'(k % 2)) errs++;
            if (f0n_a !== ((k >= 126) ? 1'b0 : 1'b1)) errs++;
            if (k > 0 && (tx_underrun_a !== 1'b0 || rx_valid_a !== 1'b0)) errs++;
            step();
        end
        chk("t1_frame_pattern", 32'(errs), 32'd0);
        chk("t1_rxvalid", 32'(rx_valid_a), 32'd1);
        chk("t1_rxdata",  rx_data_a,       32'h0000_0000);

        // 3: drop en mid-frame -> frame completes, no F0, IDLE afterwards
        errs = 0;
        for (int k = 0; k < 128; k++) begin
            if (k == 60) en_a = 1'b0;
            if (f0n_a !== 1'b1 || busy_a !== 1'b1) errs++;
            step();
        end
        chk("t3_no_f0", 32'(errs), 32'd0);
        chk("t3_rxvalid", 32'(rx_valid_a), 32'd1);
        chk("t3_busy",    32'(busy_a),     32'd0);
        chk("t3_c4",      32'(c4_a),       32'd0);
        step();
        chk("t3_idle_busy", 32'(busy_a), 32'd0);
        chk("t3_idle_c4",   32'(c4_a),   32'd0);
        chk("t3_idle_rxv",  32'(rx_valid_a), 32'd0);

        // 2: preloaded word, loopback
        word = 32'hA5A5_0F0F;
        tx_data_a  = word;
        tx_valid_a = 1'b1;
        step();
        tx_valid_a = 1'b0;
        chk("t2_held", 32'(tx_ready_a), 32'd0);
        loop_a = 1'b1;
        en_a   = 1'b1;
        step();
        step();
        step();
        chk("t2_underrun", 32'(tx_underrun_a), 32'd0);
        chk("t2_txready",  32'(tx_ready_a),    32'd1);
        errs = 0;
        for (int k = 0; k < 128; k++) begin
            if (dx_a !== word[31 - k / 4]) errs++;
            step();
        end
        chk("t2_dx_bits", 32'(errs), 32'd0);
        chk("t2_rxvalid", 32'(rx_valid_a), 32'd1);
        chk("t2_rxdata",  rx_data_a,       32'hA5A5_0F0F);
        chk("t2_next_underrun", 32'(tx_underrun_a), 32'd1);

        // 4: word offered on the p=0 load clk while holding empty
        tx_data_a  = 32'h1234_5678;
        tx_valid_a = 1'b1;
        errs = 0;
        for (int k = 0; k < 128; k++) begin
            if (dx_a !== 1'b1) errs++;
            step();
            tx_valid_a = 1'b0;
        end
        chk("t4_frameN_idle", 32'(errs), 32'd0);
        chk("t4_frameN1_underrun", 32'(tx_underrun_a), 32'd0);
        chk("t4_rx_idle_word", rx_data_a, 32'hFFFF_FFFF);
        word = 32'h1234_5678;
        errs = 0;
        for (int k = 0; k < 70; k++) begin
            if (dx_a !== word[31 - k / 4]) errs++;
            if (k == 10) begin
                chk("t5_ready_before", 32'(tx_ready_a), 32'd1);
                tx_data_a  = 32'hDEAD_BEEF;
                tx_valid_a = 1'b1;
            end
            step();
            tx_valid_a = 1'b0;
        end
        chk("t4_frameN1_bits", 32'(errs), 32'd0);
        chk("t5_held", 32'(tx_ready_a), 32'd0);

        // 5: reset at RUN clk 70
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_a("t5");
        step();
        step();
        step();
        chk("t5_word_dropped", 32'(tx_underrun_a), 32'd1);
        en_a = 1'b0;

        // 6: FRAME_BITS=8, DIV=3
        pat  = 8'hC5;
        en_b = 1'b1;
        step();
        lows = 0;
        for (int s = 0; s < 6; s++) begin
            if (f0n_b === 1'b0) lows++;
            step();
        end
        chk("t6_sync_f0_low", 32'(lows), 32'd6);
        chk("t6_clk0_underrun", 32'(tx_underrun_b), 32'd1);
        errs = 0;
        lows = 0;
        for (int k = 0; k < 96; k++) begin
            if (c4_b !== 1'((k / 3) % 2)) errs++;
            if (f0n_b === 1'b0) lows++;
            if (k > 0 && rx_valid_b !== 1'b0) errs++;
            dr_b = (k % 12 == 6) ? pat[7 - k / 12] : ~pat[7 - k / 12];
            step();
        end
        chk("t6_c4_pattern", 32'(errs), 32'd0);
        chk("t6_f0_low_clks", 32'(lows), 32'd6);
        chk("t6_rxvalid", 32'(rx_valid_b), 32'd1);
        chk("t6_rxdata",  32'(rx_data_b),  32'h0000_00C5);
        chk("t6_busy",    32'(busy_b),     32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
